// File: rtl/alu_share_arb.sv
// Round-robin arbiter that shares one external combinational ALU between two requesters.
// Optional illegal-op (non-one-hot) filtering is enabled by defining ALU_ARB_ONEHOT_CHK_EN.
module alu_share_arb #(
   parameter bit RR_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [11:0] req0_op,
   input  logic [31:0] req0_src1,
   input  logic [31:0] req0_src2,
   output logic        resp0_valid,
   input  logic        resp0_ready,
   output logic [31:0] resp0_result,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [11:0] req1_op,
   input  logic [31:0] req1_src1,
   input  logic [31:0] req1_src2,
   output logic        resp1_valid,
   input  logic        resp1_ready,
   output logic [31:0] resp1_result,
   output logic [11:0] alu_control,
   output logic [31:0] alu_src1,
   output logic [31:0] alu_src2,
   input  logic [31:0] alu_result,
   output logic        op_err
);

   logic        iss_valid_q, iss_valid_d;
   logic        iss_owner_q, iss_owner_d;
   logic [11:0] iss_op_q, iss_op_d;
   logic [31:0] iss_src1_q, iss_src1_d;
   logic [31:0] iss_src2_q, iss_src2_d;
   logic        resp0_valid_q, resp0_valid_d;
   logic [31:0] resp0_result_q, resp0_result_d;
   logic        resp1_valid_q, resp1_valid_d;
   logic [31:0] resp1_result_q, resp1_result_d;
   logic        ptr_q, ptr_d;

   logic        retire;
   logic        can_accept;
   logic        grant0, grant1;
   logic        acc0, acc1;
   logic [11:0] sel_op;

   // The issue entry retires when its owner's buffer is free or being popped this cycle.
   assign retire     = iss_valid_q &
                       (iss_owner_q ? (!resp1_valid_q | resp1_ready)
                                    : (!resp0_valid_q | resp0_ready));
   assign can_accept = !iss_valid_q | retire;

   assign grant0 = req0_valid & (!req1_valid | !ptr_q);
   assign grant1 = req1_valid & (!req0_valid |  ptr_q);

   assign req0_ready = can_accept & grant0 & !rst;
   assign req1_ready = can_accept & grant1 & !rst;
   assign acc0       = req0_valid & req0_ready;
   assign acc1       = req1_valid & req1_ready;
   assign sel_op     = acc1 ? req1_op : req0_op;

`ifdef ALU_ARB_ONEHOT_CHK_EN
   logic op_multi;
   logic op_err_q, op_err_d;

   assign op_multi = (sel_op & (sel_op - 12'd1)) != 12'd0;
   assign op_err_d = op_err_q | ((acc0 | acc1) & op_multi);
   assign op_err   = op_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) op_err_q <= 1'b0;
      else     op_err_q <= op_err_d;
   end
`else
   assign op_err = 1'b0;
`endif

   always_comb begin
      iss_valid_d    = iss_valid_q & !retire;
      iss_owner_d    = iss_owner_q;
      iss_op_d       = iss_op_q;
      iss_src1_d     = iss_src1_q;
      iss_src2_d     = iss_src2_q;
      ptr_d          = ptr_q;
      if (acc0 | acc1) begin
         iss_valid_d = 1'b1;
         iss_owner_d = acc1;
`ifdef ALU_ARB_ONEHOT_CHK_EN
         iss_op_d    = op_multi ? 12'h000 : sel_op;
`else
         iss_op_d    = sel_op;
`endif
         iss_src1_d  = acc1 ? req1_src1 : req0_src1;
         iss_src2_d  = acc1 ? req1_src2 : req0_src2;
         ptr_d       = !acc1;
      end

      // A pop and a refill in the same cycle keep the buffer valid with the new result.
      resp0_valid_d  = resp0_valid_q & !resp0_ready;
      resp0_result_d = resp0_result_q;
      resp1_valid_d  = resp1_valid_q & !resp1_ready;
      resp1_result_d = resp1_result_q;
      if (retire && !iss_owner_q) begin
         resp0_valid_d  = 1'b1;
         resp0_result_d = alu_result;
      end
      if (retire && iss_owner_q) begin
         resp1_valid_d  = 1'b1;
         resp1_result_d = alu_result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_valid_q    <= 1'b0;
         iss_owner_q    <= 1'b0;
         iss_op_q       <= 12'h000;
         iss_src1_q     <= 32'h0;
         iss_src2_q     <= 32'h0;
         resp0_valid_q  <= 1'b0;
         resp0_result_q <= 32'h0;
         resp1_valid_q  <= 1'b0;
         resp1_result_q <= 32'h0;
         ptr_q          <= RR_INIT;
      end else begin
         iss_valid_q    <= iss_valid_d;
         iss_owner_q    <= iss_owner_d;
         iss_op_q       <= iss_op_d;
         iss_src1_q     <= iss_src1_d;
         iss_src2_q     <= iss_src2_d;
         resp0_valid_q  <= resp0_valid_d;
         resp0_result_q <= resp0_result_d;
         resp1_valid_q  <= resp1_valid_d;
         resp1_result_q <= resp1_result_d;
         ptr_q          <= ptr_d;
      end
   end

   assign alu_control  = iss_valid_q ? iss_op_q   : 12'h000;
   assign alu_src1     = iss_valid_q ? iss_src1_q : 32'h0;
   assign alu_src2     = iss_valid_q ? iss_src2_q : 32'h0;
   assign resp0_valid  = resp0_valid_q;
   assign resp0_result = resp0_result_q;
   assign resp1_valid  = resp1_valid_q;
   assign resp1_result = resp1_result_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural model of the shared ALU.
module tb_alu_share_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [11:0] req0_op = '0, req1_op = '0;
   logic [31:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
   logic        resp0_valid, resp1_valid;
   logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
   logic [31:0] resp0_result, resp1_result;
   logic [11:0] alu_control;
   logic [31:0] alu_src1, alu_src2, alu_result;
   logic        op_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_share_arb #(.RR_INIT(1'b0)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_src1(req0_src1), .req0_src2(req0_src2),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_src1(req1_src1), .req1_src2(req1_src2),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
      .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
      .alu_result(alu_result), .op_err(op_err)
   );

   // Priority ALU: the highest set control bit selects the operation.
   function automatic logic [31:0] aluModel(input logic [11:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
      if (c[11]) return a + b;
      if (c[10]) return a - b;
      if (c[9])  return {31'd0, $signed(a) < $signed(b)};
      if (c[8])  return {31'd0, a < b};
      if (c[7])  return a & b;
      if (c[6])  return ~(a | b);
      if (c[5])  return a | b;
      if (c[4])  return a ^ b;
      if (c[3])  return a << b[4:0];
      if (c[2])  return a >> b[4:0];
      if (c[1])  return $unsigned($signed(a) >>> b[4:0]);
      if (c[0])  return {b[15:0], 16'h0};
      return 32'h0;
   endfunction

   assign alu_result = aluModel(alu_control, alu_src1, alu_src2);

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v0, input logic [11:0] op0, input logic [31:0] a0,
                                input logic [31:0] b0, input logic v1, input logic [11:0] op1,
                                input logic [31:0] a1, input logic [31:0] b1);
      req0_valid = v0; req0_op = op0; req0_src1 = a0; req0_src2 = b0;
      req1_valid = v1; req1_op = op1; req1_src1 = a1; req1_src2 = b1;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   int n0, n1, g;
   logic [31:0] expRes [0:7];
   logic        expPort[0:7];

   initial begin
      // Reset state, with a request pending to confirm ready stays low.
      req0_valid = 1'b1;
      #3;
      checkOutput("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
      checkOutput("rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
      checkOutput("rst_resp1_result", resp1_result, 32'd0);
      checkOutput("rst_alu_control", {20'd0, alu_control}, 32'd0);
      checkOutput("rst_op_err", {31'd0, op_err}, 32'd0);
      doReset();

      // 1: single add with latency check.
      resp0_ready = 1'b1;
      applyStimulus(1, 12'h800, 5, 7, 0, 0, 0, 0);
      #1 checkOutput("t1_req0_ready", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #1 checkOutput("t1_alu_control", {20'd0, alu_control}, 32'h800);
      checkOutput("t1_alu_src1", alu_src1, 32'd5);
      checkOutput("t1_resp0_early", {31'd0, resp0_valid}, 32'd0);
      @(negedge clk);
      #1 checkOutput("t1_resp0_valid", {31'd0, resp0_valid}, 32'd1);
      checkOutput("t1_resp0_result", resp0_result, 32'd12);
      @(negedge clk);
      #1 checkOutput("t1_resp0_popped", {31'd0, resp0_valid}, 32'd0);

      // 2: simultaneous requests, pointer at reset value.
      doReset();
      resp0_ready = 1'b1;
      resp1_ready = 1'b1;
      applyStimulus(1, 12'h400, 3, 5, 1, 12'h100, 1, 2);
      #1 checkOutput("t2_req0_ready", {31'd0, req0_ready}, 32'd1);
      checkOutput("t2_req1_ready_lo", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 1, 12'h100, 1, 2);
      #1 checkOutput("t2_req1_ready", {31'd0, req1_ready}, 32'd1);
      checkOutput("t2_alu_control0", {20'd0, alu_control}, 32'h400);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #1 checkOutput("t2_resp0_valid", {31'd0, resp0_valid}, 32'd1);
      checkOutput("t2_resp0_result", resp0_result, 32'hFFFF_FFFE);
      checkOutput("t2_alu_control1", {20'd0, alu_control}, 32'h100);
      @(negedge clk);
      #1 checkOutput("t2_resp1_valid", {31'd0, resp1_valid}, 32'd1);
      checkOutput("t2_resp1_result", resp1_result, 32'd1);

      // 3: head-of-line blocking with a full response buffer.
      doReset();
      applyStimulus(1, 12'h800, 1, 1, 0, 0, 0, 0);
      #1 checkOutput("t3_acc1", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      applyStimulus(1, 12'h800, 2, 2, 0, 0, 0, 0);
      #1 checkOutput("t3_acc2", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      applyStimulus(1, 12'h800, 3, 3, 1, 12'h800, 9, 9);
      #1 checkOutput("t3_stall_req0", {31'd0, req0_ready}, 32'd0);
      checkOutput("t3_stall_req1", {31'd0, req1_ready}, 32'd0);
      checkOutput("t3_stall_src1", alu_src1, 32'd2);
      checkOutput("t3_buf_result", resp0_result, 32'd2);
      @(negedge clk);
      applyStimulus(1, 12'h800, 3, 3, 0, 0, 0, 0);
      resp0_ready = 1'b1;
      #1 checkOutput("t3_r1_valid", {31'd0, resp0_valid}, 32'd1);
      checkOutput("t3_r1", resp0_result, 32'd2);
      checkOutput("t3_drain_ready", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #1 checkOutput("t3_r2", resp0_result, 32'd4);
      @(negedge clk);
      #1 checkOutput("t3_r3_valid", {31'd0, resp0_valid}, 32'd1);
      checkOutput("t3_r3", resp0_result, 32'd6);
      @(negedge clk);
      #1 checkOutput("t3_empty", {31'd0, resp0_valid}, 32'd0);

      // 4: both ports streaming; grants alternate and responses land two cycles later.
      doReset();
      resp0_ready = 1'b1;
      resp1_ready = 1'b1;
      n0 = 0;
      n1 = 0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         if (k < 6) applyStimulus(1, 12'h800, n0, 100, 1, 12'h800, n1, 200);
         else       applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
         #1;
         if (k < 6) begin
            g = k % 2;
            checkOutput($sformatf("t4_ready0_%0d", k), {31'd0, req0_ready}, (g == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t4_ready1_%0d", k), {31'd0, req1_ready}, (g == 1) ? 32'd1 : 32'd0);
            expPort[k] = (g == 1);
            expRes[k]  = (g == 0) ? 32'(n0 + 100) : 32'(n1 + 200);
            if (g == 0) n0++; else n1++;
         end
         if (k >= 2) begin
            if (expPort[k-2]) begin
               checkOutput($sformatf("t4_v1_%0d", k), {31'd0, resp1_valid}, 32'd1);
               checkOutput($sformatf("t4_r1_%0d", k), resp1_result, expRes[k-2]);
            end else begin
               checkOutput($sformatf("t4_v0_%0d", k), {31'd0, resp0_valid}, 32'd1);
               checkOutput($sformatf("t4_r0_%0d", k), resp0_result, expRes[k-2]);
            end
         end
      end

      // 5: reset with an in-flight issue entry and a buffered response.
      doReset();
      applyStimulus(0, 0, 0, 0, 1, 12'h800, 4, 4);
      #1 checkOutput("t5_acc1", {31'd0, req1_ready}, 32'd1);
      @(negedge clk);
      applyStimulus(1, 12'h800, 1, 2, 0, 0, 0, 0);
      #1 checkOutput("t5_acc0", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #1 checkOutput("t5_pre_resp1", resp1_result, 32'd8);
      checkOutput("t5_pre_alu", {20'd0, alu_control}, 32'h800);
      #1 rst = 1'b1;
      req0_valid = 1'b1;
      #1 checkOutput("t5_rst_req0_ready", {31'd0, req0_ready}, 32'd0);
      checkOutput("t5_rst_resp1_valid", {31'd0, resp1_valid}, 32'd0);
      checkOutput("t5_rst_resp1_result", resp1_result, 32'd0);
      checkOutput("t5_rst_alu_control", {20'd0, alu_control}, 32'd0);
      checkOutput("t5_rst_alu_src1", alu_src1, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      resp0_ready = 1'b1;
      resp1_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1 checkOutput($sformatf("t5_quiet0_%0d", k), {31'd0, resp0_valid}, 32'd0);
         checkOutput($sformatf("t5_quiet1_%0d", k), {31'd0, resp1_valid}, 32'd0);
      end
      applyStimulus(1, 12'h800, 0, 0, 1, 12'h800, 0, 0);
      #1 checkOutput("t5_ptr_req0", {31'd0, req0_ready}, 32'd1);
      checkOutput("t5_ptr_req1", {31'd0, req1_ready}, 32'd0);

      // 6: multi-hot op code.
      doReset();
      resp0_ready = 1'b1;
      applyStimulus(1, 12'h880, 6, 3, 0, 0, 0, 0);
      #1 checkOutput("t6_accept", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ALU_ARB_ONEHOT_CHK_EN
      #1 checkOutput("t6_alu_control", {20'd0, alu_control}, 32'h000);
      checkOutput("t6_op_err", {31'd0, op_err}, 32'd1);
      @(negedge clk);
      #1 checkOutput("t6_result", resp0_result, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #1 checkOutput("t6_op_err_sticky", {31'd0, op_err}, 32'd1);
`else
      #1 checkOutput("t6_alu_control", {20'd0, alu_control}, 32'h880);
      checkOutput("t6_op_err", {31'd0, op_err}, 32'd0);
      @(negedge clk);
      #1 checkOutput("t6_result", resp0_result, 32'd9);
      @(negedge clk);
      @(negedge clk);
      #1 checkOutput("t6_op_err_sticky", {31'd0, op_err}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
